// File: rtl/ice40_io_sequencer.sv
// Sequences UART rx bytes into a flat operand for an XLS computation and
// streams the flat result back out byte by byte, gating the host with CTS.
//
// state       | meaning
// COLLECT     | gathering rx bytes into flat_input, host may send
// ISSUE       | flat_input_valid high, waiting for the computation to accept
// WAIT_RESULT | flat_output_ready high, waiting for the result
// TRANSMIT    | streaming result bytes to UART tx, LSB byte first
module ice40_io_sequencer #(
  parameter int InputBytes  = 1,
  parameter int OutputBytes = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_byte,
  input  logic                     rx_byte_valid,
  output logic                     rx_byte_done,
  output logic [8*InputBytes-1:0]  flat_input,
  output logic                     flat_input_valid,
  input  logic                     flat_input_ready,
  input  logic [8*OutputBytes-1:0] flat_output,
  input  logic                     flat_output_valid,
  output logic                     flat_output_ready,
  output logic [7:0]               tx_byte,
  output logic                     tx_byte_valid,
  input  logic                     tx_byte_ready,
  output logic                     clear_to_send_out_n,
  output logic                     overrun
);

  localparam int RxCntW = (InputBytes > 1) ? $clog2(InputBytes) : 1;
  localparam int TxCntW = (OutputBytes > 1) ? $clog2(OutputBytes) : 1;
  localparam logic [RxCntW-1:0] RxLast = RxCntW'(InputBytes - 1);
  localparam logic [TxCntW-1:0] TxLast = TxCntW'(OutputBytes - 1);

  typedef enum logic [1:0] {COLLECT, ISSUE, WAIT_RESULT, TRANSMIT} state_e;

  state_e                   state_q, state_d;
  logic [RxCntW-1:0]        rx_count_q, rx_count_d;
  logic [TxCntW-1:0]        tx_count_q, tx_count_d, tx_count_inc;
  logic [8*InputBytes-1:0]  flat_input_q, flat_input_d;
  logic [8*OutputBytes-1:0] result_q, result_d;
  logic                     flat_input_valid_q, flat_input_valid_d;
  logic                     flat_output_ready_q, flat_output_ready_d;
  logic [7:0]               tx_byte_q, tx_byte_d;
  logic                     tx_byte_valid_q, tx_byte_valid_d;
  logic                     rx_byte_done_q, rx_byte_done_d;
  logic                     overrun_q, overrun_d;
  logic                     cts_n_q, cts_n_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= COLLECT;
      rx_count_q          <= '0;
      tx_count_q          <= '0;
      flat_input_q        <= '0;
      result_q            <= '0;
      flat_input_valid_q  <= 1'b0;
      flat_output_ready_q <= 1'b0;
      tx_byte_q           <= '0;
      tx_byte_valid_q     <= 1'b0;
      rx_byte_done_q      <= 1'b0;
      overrun_q           <= 1'b0;
      cts_n_q             <= 1'b0;
    end else begin
      state_q             <= state_d;
      rx_count_q          <= rx_count_d;
      tx_count_q          <= tx_count_d;
      flat_input_q        <= flat_input_d;
      result_q            <= result_d;
      flat_input_valid_q  <= flat_input_valid_d;
      flat_output_ready_q <= flat_output_ready_d;
      tx_byte_q           <= tx_byte_d;
      tx_byte_valid_q     <= tx_byte_valid_d;
      rx_byte_done_q      <= rx_byte_done_d;
      overrun_q           <= overrun_d;
      cts_n_q             <= cts_n_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    rx_count_d          = rx_count_q;
    tx_count_d          = tx_count_q;
    tx_count_inc        = tx_count_q + 1'b1;
    flat_input_d        = flat_input_q;
    result_d            = result_q;
    flat_input_valid_d  = flat_input_valid_q;
    flat_output_ready_d = flat_output_ready_q;
    tx_byte_d           = tx_byte_q;
    tx_byte_valid_d     = tx_byte_valid_q;
    rx_byte_done_d      = 1'b0;
    overrun_d           = overrun_q;
    cts_n_d             = cts_n_q;

    // Bytes arriving outside COLLECT are dropped but remembered.
    if (rx_byte_valid && (state_q != COLLECT)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      COLLECT: begin
        if (rx_byte_valid) begin
          flat_input_d[{rx_count_q, 3'b000} +: 8] = rx_byte;
          rx_byte_done_d = 1'b1;
          if (rx_count_q == RxLast) begin
            rx_count_d         = '0;
            state_d            = ISSUE;
            flat_input_valid_d = 1'b1;
            cts_n_d            = 1'b1;
          end else begin
            rx_count_d = rx_count_q + 1'b1;
          end
        end
      end
      ISSUE: begin
        if (flat_input_valid_q && flat_input_ready) begin
          flat_input_valid_d  = 1'b0;
          flat_output_ready_d = 1'b1;
          state_d             = WAIT_RESULT;
        end
      end
      WAIT_RESULT: begin
        if (flat_output_ready_q && flat_output_valid) begin
          result_d            = flat_output;
          flat_output_ready_d = 1'b0;
          tx_count_d          = '0;
          tx_byte_d           = flat_output[7:0];
          tx_byte_valid_d     = 1'b1;
          state_d             = TRANSMIT;
        end
      end
      TRANSMIT: begin
        if (tx_byte_valid_q && tx_byte_ready) begin
          if (tx_count_q == TxLast) begin
            tx_count_d      = '0;
            tx_byte_valid_d = 1'b0;
            cts_n_d         = 1'b0;
            state_d         = COLLECT;
          end else begin
            tx_count_d = tx_count_inc;
            tx_byte_d  = result_q[{tx_count_inc, 3'b000} +: 8];
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign rx_byte_done        = rx_byte_done_q;
  assign flat_input          = flat_input_q;
  assign flat_input_valid    = flat_input_valid_q;
  assign flat_output_ready   = flat_output_ready_q;
  assign tx_byte             = tx_byte_q;
  assign tx_byte_valid       = tx_byte_valid_q;
  assign clear_to_send_out_n = cts_n_q;
  assign overrun             = overrun_q;

endmodule

// File: doc/ice40_io_sequencer.md
Name: ice40_io_sequencer

Overview:
Control block between the ice40 UART byte interfaces and a flat-bit XLS computation. It gathers InputBytes received bytes into a flat input word and presents it to the computation with a valid/ready handshake. It then captures the flat result and streams OutputBytes bytes to the UART transmitter. It drives the host clear-to-send line so the host only sends while the sequencer can accept bytes.

Parameters:
InputBytes, 1, number of rx bytes gathered per transaction (>=1)
OutputBytes, 4, number of tx bytes emitted per transaction (>=1)

Ports:
clk  input  1  single clock for the whole block
rst_n  input  1  reset; asynchronous, active-low
rx_byte  input  8  received byte from UART rx
rx_byte_valid  input  1  one-cycle strobe: rx_byte holds a new byte
rx_byte_done  output  1  one-cycle strobe: rx byte accepted into the flat input
flat_input  output  8*InputBytes  gathered operand; byte k at bits [8k+7:8k]
flat_input_valid  output  1  operand valid to computation
flat_input_ready  input  1  computation accepts operand
flat_output  input  8*OutputBytes  result from computation
flat_output_valid  input  1  result valid
flat_output_ready  output  1  sequencer accepts result
tx_byte  output  8  byte to UART tx
tx_byte_valid  output  1  tx_byte valid
tx_byte_ready  input  1  UART tx accepts byte
clear_to_send_out_n  output  1  0 = host may send
overrun  output  1  sticky: a byte arrived while not in COLLECT

Behaviour:
- Reset (async assert, sync release): state=COLLECT; byte counters=0; flat_input=0; result register=0; flat_input_valid=0; flat_output_ready=0; tx_byte_valid=0; tx_byte=0; rx_byte_done=0; overrun=0; clear_to_send_out_n=0.
- States: COLLECT, ISSUE, WAIT_RESULT, TRANSMIT. All outputs are registered.
- COLLECT: clear_to_send_out_n=0. On rx_byte_valid, write rx_byte into byte slot rx_count and pulse rx_byte_done the next cycle.
  - If rx_count==InputBytes-1, reset rx_count to 0, go to ISSUE and assert clear_to_send_out_n=1 in the same edge. Otherwise increment rx_count.
- ISSUE: flat_input_valid=1. flat_input is held stable until the handshake cycle where valid&&ready. On that edge, drop valid and go to WAIT_RESULT.
- WAIT_RESULT: flat_output_ready=1. When valid&&ready, capture flat_output into the result register, drop ready and go to TRANSMIT with tx_count=0.
- TRANSMIT: tx_byte = result byte tx_count (LSB byte first) and tx_byte_valid=1.
  - On each valid&&ready edge, advance tx_count and load the next byte. Back-to-back acceptance streams one byte per cycle.
  - After byte OutputBytes-1 is accepted, drop tx_byte_valid, go to COLLECT and release clear_to_send_out_n=0 on the same edge.
  - tx_byte and tx_byte_valid do not change while valid&&!ready.
- Min latency from last rx strobe to first tx_byte_valid: 3 cycles (ready inputs held high).
- Counter widths: clog2 of the byte count, minimum 1 bit. Wrap happens only through the explicit terminal compare; no modular overflow path.
- Boundaries:
  - An rx_byte_valid outside COLLECT drops the byte and sets overrun; flat_input is not modified.
  - An rx_byte_valid on the same edge COLLECT exits is accepted as the final byte.
  - overrun clears only on reset.
  - InputBytes=1 or OutputBytes=1: single-slot operation, the terminal compare is on count 0.
  - rst_n asserted mid-transaction returns to the reset state immediately. A partial operand or result is discarded and no further tx bytes are emitted.
  - flat_output_valid seen outside WAIT_RESULT is ignored (ready=0).

Test Plan:
- InputBytes=1, OutputBytes=4; rx 0x55; computation model returns 0x56575859.
  - Required: flat_input=0x55 with valid.
  - Required: tx bytes 0x59,0x58,0x57,0x56 in order.
  - Required: cts_n=1 from rx accept until the last tx accept, then 0.
- tx_byte_ready toggled 1-0-0-1 randomly → tx_byte is stable during stalls; exactly 4 bytes emitted with no duplicates or skips.
- InputBytes=3; rx 0x11,0x22,0x33 with gaps → flat_input=0x332211. rx_byte_done pulses 3 times, once per byte.
- rx strobe 0xAA during WAIT_RESULT → overrun=1 and flat_input is unchanged. The next transaction still completes correctly.
- flat_input_ready held 0 for 10 cycles → flat_input_valid and flat_input are stable throughout; the handshake completes when ready rises.
- rst_n pulsed low during TRANSMIT after 2 bytes → outputs return to reset values asynchronously and no further tx bytes appear. A fresh rx 0x55 then yields the full 4-byte sequence.
